// File: rtl/out_arb_pkg.sv
// Shared types and the round-robin search used by the output arbiter.
package out_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam int RR_MAX = 16;

  // First set bit of mask at or after ptr, wrapping modulo n (n <= RR_MAX).
  // Returns ptr when mask is empty; callers only use it when some bit is set.
  function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] mask,
                                         input logic [3:0] ptr, input int n);
    logic [3:0] res;
    logic       found;
    logic [4:0] idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= 5'(n)) idx = idx - 5'(n);
      if (i < n && !found && mask[idx[3:0]]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/out_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_pick
  import out_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx
);

  logic [RR_MAX-1:0] mask_w;

  assign mask_w = RR_MAX'(mask);
  assign idx    = PW'(rr_next(mask_w, 4'(ptr), N));

endmodule

// File: rtl/out_arb.sv
// Round-robin arbiter sharing one registered output beat between N requesters,
// granting bursts of up to MAX_BURST beats and rotating priority on release.
module out_arb
  import out_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int PW        = $clog2(N),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic               ref_clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [PW-1:0]      out_src,
  input  logic               out_ready
);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [PW-1:0]     out_src_q, out_src_d;

  logic [PW-1:0]     pick_idx;
  logic              slot_free;
  logic              rel;
  logic [CW-1:0]     cnt_inc;

  rr_pick #(.N(N)) u_pick (
    .mask (req_valid),
    .ptr  (ptr_q),
    .idx  (pick_idx)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    req_ready   = '0;
    rel         = 1'b0;
    slot_free   = ~out_valid_q | out_ready;

    // Downstream drain; a transfer below refills the slot in the same cycle.
    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_q] = slot_free;
        if (slot_free) begin
          if (req_valid[grant_q]) begin
            out_d       = req_data[int'(grant_q)*WIDTH +: WIDTH];
            out_valid_d = 1'b1;
            out_src_d   = grant_q;
            cnt_d       = cnt_inc;
            if (cnt_inc == CW'(MAX_BURST)) rel = 1'b1;
          end else begin
            // Requester went quiet while we could have taken a beat.
            rel = 1'b1;
          end
        end
        if (rel) begin
          ptr_d   = (grant_q == PW'(N - 1)) ? '0 : grant_q + PW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule
